// File: rtl/rvvi_depacketizer.sv
// Purpose : receives RVVI trace frames from an Ethernet MAC RX stream, checks the header and length, and rebuilds the RVVI record.
// Latency : RvviValid rises the cycle after the final payload beat; there is one bubble cycle between frames.
// Backpr. : RvviAxiRready is registered and drops for the whole HOLD state, until RvviValid & RvviReady.
// Ports   : m_axi_aclk/m_axi_aresetn clock and async active-low reset; RvviAxiR* is the 32-bit AXI-Stream input;
//           ExpDstMac/ExpSrcMac/ExpEthType are the required header fields; Rvvi/FrameCount/RvviValid/RvviReady is
//           the record output; GoodFrames/BadFrames/SeqError are the statistics.
module rvvi_depacketizer #(
    parameter int         RVVI_WIDTH        = 560,
    parameter int         FRAME_COUNT_WIDTH = 16,
    parameter int         PAYLOAD_WORDS     = (RVVI_WIDTH + 31) / 32,
    parameter logic [3:0] LAST_KEEP         = (RVVI_WIDTH % 32 == 0) ? 4'hF
                                              : 4'((1 << ((RVVI_WIDTH % 32 + 7) / 8)) - 1)
) (
    input  logic                         m_axi_aclk,
    input  logic                         m_axi_aresetn,
    input  logic [31:0]                  RvviAxiRdata,
    input  logic [3:0]                   RvviAxiRstrb,
    input  logic                         RvviAxiRlast,
    input  logic                         RvviAxiRvalid,
    output logic                         RvviAxiRready,
    input  logic [47:0]                  ExpDstMac,
    input  logic [47:0]                  ExpSrcMac,
    input  logic [15:0]                  ExpEthType,
    output logic [RVVI_WIDTH-1:0]        Rvvi,
    output logic [FRAME_COUNT_WIDTH-1:0] FrameCount,
    output logic                         RvviValid,
    input  logic                         RvviReady,
    output logic [31:0]                  GoodFrames,
    output logic [15:0]                  BadFrames,
    output logic                         SeqError
);

    // The word counter serves both the 4-word header and the payload.
    localparam int CW    = $clog2(PAYLOAD_WORDS > 4 ? PAYLOAD_WORDS : 4);
    localparam int EXT_W = PAYLOAD_WORDS * 32;
    localparam logic [CW-1:0] LAST_IDX = CW'(PAYLOAD_WORDS - 1);
    localparam logic [CW-1:0] HDR_LAST = CW'(3);
    localparam logic [FRAME_COUNT_WIDTH-1:0] FC_ONE = FRAME_COUNT_WIDTH'(1);

    typedef enum logic [1:0] {S_HDR, S_PAY, S_DROP, S_HOLD} state_t;

    state_t                         state;
    logic [CW-1:0]                  cnt;
    logic [FRAME_COUNT_WIDTH-1:0]   fc_q;
    logic [FRAME_COUNT_WIDTH-1:0]   prev_fc;
    logic                           have_prev;

    logic                  beat;
    logic                  hdr_ok;
    logic [15:0]           bad_next;
    logic [RVVI_WIDTH-1:0] wr_mask;
    logic [RVVI_WIDTH-1:0] wr_dat;

    assign beat     = RvviAxiRvalid & RvviAxiRready;
    assign bad_next = (BadFrames == 16'hFFFF) ? BadFrames : BadFrames + 16'd1;

    // The current word is placed at bit 32*cnt. The truncating cast drops the
    // part of the final word that lies above RVVI_WIDTH.
    assign wr_dat  = RVVI_WIDTH'(EXT_W'(RvviAxiRdata) << {cnt, 5'd0});
    assign wr_mask = RVVI_WIDTH'(EXT_W'(32'hFFFF_FFFF) << {cnt, 5'd0});

    // Each header word is checked as it arrives. A partial word or an early
    // tlast also makes the header bad.
    always_comb begin
        hdr_ok = 1'b0;
        case (cnt)
            CW'(0):  hdr_ok = (RvviAxiRdata == ExpDstMac[31:0]);
            CW'(1):  hdr_ok = (RvviAxiRdata == {ExpSrcMac[15:0], ExpDstMac[47:32]});
            CW'(2):  hdr_ok = (RvviAxiRdata == ExpSrcMac[47:16]);
            default: hdr_ok = (RvviAxiRdata[15:0] == ExpEthType);
        endcase
        hdr_ok = hdr_ok && (RvviAxiRstrb == 4'hF) && !RvviAxiRlast;
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state         <= S_HDR;
            cnt           <= '0;
            fc_q          <= '0;
            prev_fc       <= '0;
            have_prev     <= 1'b0;
            RvviAxiRready <= 1'b0;
            RvviValid     <= 1'b0;
            Rvvi          <= '0;
            FrameCount    <= '0;
            GoodFrames    <= '0;
            BadFrames     <= '0;
            SeqError      <= 1'b0;
        end else begin
            // Ready is held low only while a record waits in HOLD.
            RvviAxiRready <= 1'b1;
            case (state)
                S_HDR: begin
                    if (beat) begin
                        if (!hdr_ok) begin
                            BadFrames <= bad_next;
                            cnt       <= '0;
                            state     <= RvviAxiRlast ? S_HDR : S_DROP;
                        end else if (cnt == HDR_LAST) begin
                            fc_q  <= RvviAxiRdata[31:16];
                            cnt   <= '0;
                            state <= S_PAY;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                S_PAY: begin
                    if (beat) begin
                        Rvvi <= (Rvvi & ~wr_mask) | (wr_dat & wr_mask);
                        if (cnt != LAST_IDX) begin
                            if (RvviAxiRlast) begin
                                // Short frame: tlast before the final word.
                                BadFrames <= bad_next;
                                cnt       <= '0;
                                state     <= S_HDR;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end else begin
                            cnt <= '0;
                            if (RvviAxiRstrb != LAST_KEEP || !RvviAxiRlast) begin
                                BadFrames <= bad_next;
                                state     <= RvviAxiRlast ? S_HDR : S_DROP;
                            end else begin
                                state         <= S_HOLD;
                                RvviValid     <= 1'b1;
                                RvviAxiRready <= 1'b0;
                                FrameCount    <= fc_q;
                                // The first good frame only seeds the expected count.
                                if (have_prev && fc_q != prev_fc + FC_ONE) begin
                                    SeqError <= 1'b1;
                                end
                                prev_fc   <= fc_q;
                                have_prev <= 1'b1;
                            end
                        end
                    end
                end
                S_DROP: begin
                    if (beat && RvviAxiRlast) begin
                        state <= S_HDR;
                    end
                end
                S_HOLD: begin
                    if (RvviReady) begin
                        RvviValid  <= 1'b0;
                        GoodFrames <= GoodFrames + 32'd1;
                        state      <= S_HDR;
                    end else begin
                        RvviAxiRready <= 1'b0;
                    end
                end
                default: state <= S_HDR;
            endcase
        end
    end

endmodule
